// File: rtl/vip_pkg.sv
// vip_pkg: shared defaults for the binary video-processing stages.
package vip_pkg;
   localparam int IMG_HDISP_DEF = 640;
   localparam int IMG_VDISP_DEF = 480;
   localparam int SYNC_DLY      = 3;
endpackage

// File: rtl/vip_bin_line_buffer.sv
// vip_bin_line_buffer: two cascaded 1-bit shift RAMs giving the pixel one and two lines above.
module vip_bin_line_buffer
   import vip_pkg::*;
#(
   parameter int DEPTH = IMG_HDISP_DEF
)(
   input  logic clk,
   input  logic rst_n,
   input  logic shift_en,
   input  logic din,
   output logic tap1,
   output logic tap2
);
   localparam int AW = $clog2(DEPTH);

   logic          r_mem1 [DEPTH];
   logic          r_mem2 [DEPTH];
   logic [AW-1:0] r_ptr;

   // storage is left unreset; the top masks stale lines with its row counter
   always_ff @(posedge clk) begin
      if (shift_en) begin
         r_mem1[r_ptr] <= din;
         r_mem2[r_ptr] <= r_mem1[r_ptr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
         tap1  <= 1'b0;
         tap2  <= 1'b0;
      end else if (shift_en) begin
         r_ptr <= (r_ptr == AW'(DEPTH-1)) ? '0 : r_ptr + 1'b1;
         tap1  <= r_mem1[r_ptr];
         tap2  <= r_mem2[r_ptr];
      end
   end
endmodule

// File: rtl/vip_bin_dilation_3x3.sv
// vip_bin_dilation_3x3: streaming binary 3x3 dilation, 3 clk latency, output shifted by (+1,+1).
// Define VIP_DILATION_CROSS_EN for a cross-shaped element instead of the full square.
module vip_bin_dilation_3x3
   import vip_pkg::*;
#(
   parameter int IMG_HDISP = IMG_HDISP_DEF,
   parameter int IMG_VDISP = IMG_VDISP_DEF
)(
   input  logic clk,
   input  logic rst_n,
   input  logic per_frame_vsync,
   input  logic per_frame_href,
   input  logic per_frame_clken,
   input  logic per_img_bit,
   output logic post_frame_vsync,
   output logic post_frame_href,
   output logic post_frame_clken,
   output logic post_img_bit
);
   localparam int CW = $clog2(IMG_HDISP);
   localparam int RW = $clog2(IMG_VDISP);

   logic [SYNC_DLY-1:0] r_vs_sr, r_href_sr, r_clken_sr;
   logic [CW-1:0]       r_col;
   logic [RW-1:0]       r_row;
   logic                r_s1_acc, r_s1_cur, r_s1_fall, r_s1_ge1, r_s1_ge2;
   logic [2:0]          r_win_t, r_win_m, r_win_b;
   logic                r_out;
   logic                w_acc, w_href_fall, w_vs_fall, w_tap1, w_tap2, w_dil;

   assign w_acc       = per_frame_href & per_frame_clken;
   assign w_href_fall = r_href_sr[0] & ~per_frame_href;
   assign w_vs_fall   = r_vs_sr[0] & ~per_frame_vsync;

   vip_bin_line_buffer #(.DEPTH(IMG_HDISP)) u_lbuf (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (w_acc),
      .din      (per_img_bit),
      .tap1     (w_tap1),
      .tap2     (w_tap2)
   );

`ifdef VIP_DILATION_CROSS_EN
   assign w_dil = r_win_t[1] | (|r_win_m) | r_win_b[1];
`else
   assign w_dil = |{r_win_t, r_win_m, r_win_b};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vs_sr    <= '0;
         r_href_sr  <= '0;
         r_clken_sr <= '0;
         r_col      <= '0;
         r_row      <= '0;
         r_s1_acc   <= 1'b0;
         r_s1_cur   <= 1'b0;
         r_s1_fall  <= 1'b0;
         r_s1_ge1   <= 1'b0;
         r_s1_ge2   <= 1'b0;
         r_win_t    <= '0;
         r_win_m    <= '0;
         r_win_b    <= '0;
         r_out      <= 1'b0;
      end else begin
         r_vs_sr    <= {r_vs_sr[SYNC_DLY-2:0], per_frame_vsync};
         r_href_sr  <= {r_href_sr[SYNC_DLY-2:0], per_frame_href};
         r_clken_sr <= {r_clken_sr[SYNC_DLY-2:0], per_frame_clken};
         r_col      <= w_acc ? ((r_col == CW'(IMG_HDISP-1)) ? r_col : r_col + 1'b1)
                             : (w_href_fall ? '0 : r_col);
         r_row      <= w_vs_fall ? '0
                     : (w_href_fall && r_row != RW'(IMG_VDISP-1)) ? r_row + 1'b1 : r_row;
         r_s1_acc   <= w_acc;
         r_s1_fall  <= w_href_fall;
         // row masks travel with the pixel so the taps are zero-padded at the frame top
         if (w_acc) begin
            r_s1_cur <= per_img_bit;
            r_s1_ge1 <= r_row != '0;
            r_s1_ge2 <= r_row > RW'(1);
         end
         if (r_s1_acc) begin
            r_win_t <= {r_win_t[1:0], w_tap2 & r_s1_ge2};
            r_win_m <= {r_win_m[1:0], w_tap1 & r_s1_ge1};
            r_win_b <= {r_win_b[1:0], r_s1_cur};
         end else if (r_s1_fall) begin
            r_win_t <= '0;
            r_win_m <= '0;
            r_win_b <= '0;
         end
         r_out      <= w_dil & r_href_sr[SYNC_DLY-2];
      end
   end

   assign post_frame_vsync = r_vs_sr[SYNC_DLY-1];
   assign post_frame_href  = r_href_sr[SYNC_DLY-1];
   assign post_frame_clken = r_clken_sr[SYNC_DLY-1];
   assign post_img_bit     = r_out;
endmodule
